// File: rtl/dual_slave_sequencer_if.sv
// Handshake bundle between the sequencer and whoever requests rounds.
// The slave modport is the sequencer side; master is the requester side.
interface dual_slave_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             trigger_1;
  logic             trigger_2;
  logic             done_1;
  logic             done_2;
  logic [CNT_W-1:0] slave_out_1;
  logic [CNT_W-1:0] slave_out_2;
  logic             busy;
  logic             round_done;

  modport master (
    output start,
    input  trigger_1, trigger_2, done_1, done_2,
    input  slave_out_1, slave_out_2, busy, round_done
  );

  modport slave (
    input  start,
    output trigger_1, trigger_2, done_1, done_2,
    output slave_out_1, slave_out_2, busy, round_done
  );
endinterface

// File: rtl/dual_slave_sequencer.sv
// Controller FSM chaining two identical counter slaves through trigger/done
// handshakes: slave A runs, then slave B, then a round_done pulse.
module dual_slave_sequencer #(
  parameter int CNT_W     = 4,
  parameter int COUNT_MAX = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_slave_sequencer_if.slave   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TRIG1 = 3'd1;
  localparam logic [2:0] WAIT1 = 3'd2;
  localparam logic [2:0] TRIG2 = 3'd3;
  localparam logic [2:0] WAIT2 = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_TERM = COUNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic             trig1_reg;
  logic             trig2_reg;
  logic             busy_reg;
  logic             round_done_reg;

  logic [1:0]       trig_vec;
  logic [1:0]       done_vec;
  logic [CNT_W-1:0] cnt_arr [2];

  assign trig_vec = {trig2_reg, trig1_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = TRIG1;
      TRIG1:   state_next = WAIT1;
      WAIT1:   if (done_vec[0]) state_next = TRIG2;
      TRIG2:   state_next = WAIT2;
      WAIT2:   if (done_vec[1]) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg      <= IDLE;
      trig1_reg      <= 1'b0;
      trig2_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      round_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      trig1_reg      <= (state_next == TRIG1);
      trig2_reg      <= (state_next == TRIG2);
      busy_reg       <= (state_next != IDLE);
      round_done_reg <= (state_next == FIN);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slave
      logic             st_reg;
      logic             done_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_inc;

      assign cnt_inc = cnt_reg + CNT_ONE;

      // done stays high for one cycle while still in S_RUN; that cycle only
      // clears it and drops back to idle with the count parked at COUNT_MAX.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          st_reg   <= S_IDLE;
          cnt_reg  <= '0;
          done_reg <= 1'b0;
        end else if (st_reg == S_IDLE) begin
          if (trig_vec[gi]) begin
            cnt_reg <= '0;
            st_reg  <= S_RUN;
          end
        end else if (done_reg) begin
          done_reg <= 1'b0;
          st_reg   <= S_IDLE;
        end else begin
          cnt_reg <= cnt_inc;
          if (cnt_inc == CNT_TERM) done_reg <= 1'b1;
        end
      end

      assign done_vec[gi] = done_reg;
      assign cnt_arr[gi]  = cnt_reg;
    end
  endgenerate

  assign bus.trigger_1   = trig1_reg;
  assign bus.trigger_2   = trig2_reg;
  assign bus.done_1      = done_vec[0];
  assign bus.done_2      = done_vec[1];
  assign bus.slave_out_1 = cnt_arr[0];
  assign bus.slave_out_2 = cnt_arr[1];
  assign bus.busy        = busy_reg;
  assign bus.round_done  = round_done_reg;

endmodule

// File: tb/tb_dual_slave_sequencer.sv
// Bench for dual_slave_sequencer: two instances (COUNT_MAX 9 and 1) share the
// stimulus and are compared every cycle against a round-offset timing model.
module tb_dual_slave_sequencer;

  localparam int M_A = 9;
  localparam int M_B = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dual_slave_sequencer_if #(.CNT_W(4)) bus_a ();
  dual_slave_sequencer_if #(.CNT_W(4)) bus_b ();

  dual_slave_sequencer #(.CNT_W(4), .COUNT_MAX(M_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  dual_slave_sequencer #(.CNT_W(4), .COUNT_MAX(M_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a round is described only by its offset d from the start edge.
  int         act [2];
  int         d   [2];
  logic [3:0] eo1 [2];
  logic [3:0] eo2 [2];

  typedef struct {
    logic        r;
    logic        s;
    logic [13:0] exp;
  } vec_t;

  vec_t tv [6];

  function automatic logic [13:0] pk(logic t1, logic t2, logic d1, logic d2,
                                     logic [3:0] o1, logic [3:0] o2,
                                     logic b, logic rd);
    return {t1, t2, d1, d2, o1, o2, b, rd};
  endfunction

  function automatic logic [13:0] dut_vec(int i);
    if (i == 0)
      return pk(bus_a.trigger_1, bus_a.trigger_2, bus_a.done_1, bus_a.done_2,
                bus_a.slave_out_1, bus_a.slave_out_2, bus_a.busy, bus_a.round_done);
    return pk(bus_b.trigger_1, bus_b.trigger_2, bus_b.done_1, bus_b.done_2,
              bus_b.slave_out_1, bus_b.slave_out_2, bus_b.busy, bus_b.round_done);
  endfunction

  function automatic logic [13:0] model_vec(int i);
    int m;
    bit on;
    m  = (i == 0) ? M_A : M_B;
    on = (act[i] != 0);
    return pk(on && d[i] == 0, on && d[i] == m + 2, on && d[i] == m + 1,
              on && d[i] == 2 * m + 3, eo1[i], eo2[i],
              on && d[i] <= 2 * m + 4, on && d[i] == 2 * m + 4);
  endfunction

  task automatic model_update(int i, logic r, logic s);
    int m;
    m = (i == 0) ? M_A : M_B;
    if (r) begin
      act[i] = 0;
      d[i]   = 0;
      eo1[i] = '0;
      eo2[i] = '0;
    end else begin
      // A new round can only be accepted once the previous one is back in IDLE.
      if (s && (act[i] == 0 || d[i] >= 2 * m + 5)) begin
        act[i] = 1;
        d[i]   = 0;
      end else if (act[i] != 0 && d[i] < 100000) begin
        d[i] = d[i] + 1;
      end
      if (act[i] != 0) begin
        if (d[i] >= 1 && d[i] <= m + 1) eo1[i] = 4'(d[i] - 1);
        if (d[i] >= m + 3 && d[i] <= 2 * m + 3) eo2[i] = 4'(d[i] - m - 3);
      end
    end
  endtask

  task automatic check_vec(string name, logic [13:0] got, logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
    end
  endtask

  task automatic step(logic r, logic s);
    rst_n       = r;
    bus_a.start = s;
    bus_b.start = s;
    @(posedge clk);
    model_update(0, r, s);
    model_update(1, r, s);
    #1;
    check_vec("model_a", dut_vec(0), model_vec(0));
    check_vec("model_b", dut_vec(1), model_vec(1));
    cyc++;
  endtask

  initial begin
    int rd_at, idle_at, t1_cnt, t2_cnt, tb_cnt, overlap, found;

    rst_n       = 1'b1;
    bus_a.start = 1'b1;
    bus_b.start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; d[i] = 0; eo1[i] = '0; eo2[i] = '0;
    end

    tv[0] = '{1'b1, 1'b1, 14'h0};
    tv[1] = '{1'b1, 1'b1, 14'h0};
    tv[2] = '{1'b0, 1'b1, pk(1, 0, 0, 0, 4'd0, 4'd0, 1, 0)};
    tv[3] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 4'd0, 4'd0, 1, 0)};
    tv[4] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 4'd1, 4'd0, 1, 0)};
    tv[5] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 4'd2, 4'd0, 1, 0)};

    for (int i = 0; i < 6; i++) begin
      step(tv[i].r, tv[i].s);
      check_vec("table", dut_vec(0), tv[i].exp);
    end

    // Single round on A with start toggling while busy.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    rd_at = -1; idle_at = -1; t1_cnt = 0; t2_cnt = 0;
    for (int j = 1; j <= 40 && idle_at < 0; j++) begin
      step(1'b0, (j % 3 == 0) ? 1'b1 : 1'b0);
      if (bus_a.round_done) rd_at = j;
      if (bus_a.trigger_1) t1_cnt++;
      if (bus_a.trigger_2) t2_cnt++;
      if (!bus_a.busy) idle_at = j;
    end
    check_int("a_round_done_at", rd_at, 2 * M_A + 4);
    check_int("a_idle_at", idle_at, 2 * M_A + 5);
    check_int("a_extra_trig1", t1_cnt, 0);
    check_int("a_trig2_count", t2_cnt, 1);
    check_int("a_hold_out1", int'(bus_a.slave_out_1), M_A);
    check_int("a_hold_out2", int'(bus_a.slave_out_2), M_A);

    // Short round on B.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    rd_at = -1; idle_at = -1;
    for (int j = 1; j <= 20 && idle_at < 0; j++) begin
      step(1'b0, 1'b0);
      if (bus_b.round_done) rd_at = j;
      if (!bus_b.busy) idle_at = j;
    end
    check_int("b_round_done_at", rd_at, 6);
    check_int("b_idle_at", idle_at, 7);
    check_int("b_hold_out2", int'(bus_b.slave_out_2), M_B);

    // Continuous start for 100 cycles.
    step(1'b1, 1'b0);
    t1_cnt = 0; tb_cnt = 0; overlap = 0;
    for (int j = 0; j < 100; j++) begin
      step(1'b0, 1'b1);
      if (bus_a.trigger_1) t1_cnt++;
      if (bus_b.trigger_1) tb_cnt++;
      if ((bus_a.trigger_1 && bus_a.trigger_2) || (bus_b.trigger_1 && bus_b.trigger_2))
        overlap++;
    end
    check_int("a_rounds_100", t1_cnt, 5);
    check_int("b_rounds_100", tb_cnt, 13);
    check_int("trig_overlap", overlap, 0);

    // Mid-run reset while slave B of instance A counts.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    found = 0;
    for (int j = 0; j < 40 && found == 0; j++) begin
      step(1'b0, 1'b0);
      if (bus_a.slave_out_2 == 4'd4 && bus_a.busy) found = 1;
    end
    check_int("a_reached_out2_4", found, 1);
    step(1'b1, 1'b0);
    check_vec("mid_reset", dut_vec(0), 14'h0);
    step(1'b0, 1'b1);
    check_vec("restart", dut_vec(0), pk(1, 0, 0, 0, 4'd0, 4'd0, 1, 0));

    // Random traffic with varying start density and rare resets.
    for (int blk = 0; blk < 10; blk++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int j = 0; j < 200; j++) begin
        step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
